vscale_wb_stage: RTL and testbench
==================================

# vscale_wb_stage

Writeback pipeline stage, sitting between the DX stage (ALU, CSR read, data-memory request) and the register file. Captures DX results on each un-stalled clock edge, extracts and sign/zero-extends load data returning from data memory, selects the writeback source, and drives the register-file write port. Also produces the bypass data and hazard indications that the DX operand muxes consume on the next instruction.

## Interface
- `XPR_LEN`, 32, datapath width.
- `REG_ADDR_WIDTH`, 5, register index width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `dx_valid`  in  1  DX holds a valid instruction.
- `dx_wr_reg`  in  1  instruction writes `rd`.
- `dx_reg_to_wr`  in  REG_ADDR_WIDTH  `rd` index.
- `dx_wb_src_sel`  in  2  writeback source: ALU / MEM / CSR.
- `dx_mem_type`  in  3  load funct3: LB, LH, LW, LBU, LHU.
- `dx_alu_out`  in  XPR_LEN  ALU result; for loads, the byte address.
- `csr_rdata_WB`  in  XPR_LEN  CSR read data, valid in WB.
- `dmem_rdata`  in  XPR_LEN  data-memory read word, valid when `dmem_wait`=0.
- `dmem_wait`  in  1  data memory not yet ready.
- `stall_WB`  in  1  hold WB register contents.
- `kill_DX`  in  1  squash the DX instruction (insert bubble).
- `rs1_addr_DX`, `rs2_addr_DX`  in  REG_ADDR_WIDTH  DX source indices.
- `wr_reg_WB`  out  1  register-file write enable.
- `reg_to_wr_WB`  out  REG_ADDR_WIDTH  write index.
- `wb_data_WB`  out  XPR_LEN  write data (also the bypass data).
- `stall_req_WB`  out  1  WB load waiting on memory.
- `bypass_rs1`, `bypass_rs2`  out  1  DX operand sources from `wb_data_WB`.
- `raw_hazard`  out  1  DX must stall for a RAW dependency on WB.

## Operation
- WB register fields: `valid`, `wr_reg`, `reg_to_wr`, `wb_src_sel`, `mem_type`, `alu_out`.
- Posedge, `stall_WB`=1: all fields hold. `stall_WB` takes priority over `kill_DX`.
- Posedge, `stall_WB`=0, and (`kill_DX`=1 or `dx_valid`=0): `valid`←0 (bubble). Other fields are don't-care, but `wr_reg` is cleared.
- Posedge, otherwise: all fields load from their `dx_*` inputs.
- Load alignment uses `alu_out[1:0]`:
  - LB/LBU: byte `addr[1:0]`, sign- or zero-extended.
  - LH/LHU: half `addr[1]`, sign- or zero-extended; `addr[0]` is ignored.
  - LW: full word; low bits are ignored. Misalignment is trapped upstream.
- `wb_data_WB` by `wb_src_sel`:
  - ALU: `alu_out`.
  - MEM: aligned load data.
  - CSR: `csr_rdata_WB`.
  - Reserved encoding: 0.
- `load_wait` = `valid` & MEM source & `dmem_wait`.
- `stall_req_WB` = `load_wait`.
- `wr_reg_WB` = `valid` & `wr_reg` & (`reg_to_wr`≠0) & !`load_wait`.
- `match_rsN` = `valid` & `wr_reg` & (`reg_to_wr`≠0) & (`reg_to_wr`==`rsN_addr_DX`).

## Timing
- Reset (asynchronous, immediate): all WB fields clear to 0.
- Outputs while in reset: `wr_reg_WB`=0, `reg_to_wr_WB`=0, `wb_data_WB`=0, `stall_req_WB`=0, `bypass_rs1`=0, `bypass_rs2`=0, `raw_hazard`=0.
- Latency: one cycle from DX capture to WB outputs. All outputs are combinational from WB state plus `dmem_*`, `csr_rdata_WB` and `rs*_addr_DX`.
- A load occupies WB until the first cycle with `dmem_wait`=0. Writeback happens in that cycle; the external control drives `stall_WB`=`stall_req_WB`.
- Register write commits at the next posedge after `wr_reg_WB`=1 (register-file behaviour).
- Reset asserted during a load wait: the instruction is discarded with no write.
- Writes to x0 never assert `wr_reg_WB` and never match a source register.

## Configuration
- `VSCALE_WB_BYPASS_EN` defined:
  - `bypass_rsN` = `match_rsN` & !`load_wait`.
  - `raw_hazard` = (`match_rs1` | `match_rs2`) & `load_wait`.
- `VSCALE_WB_BYPASS_EN` undefined:
  - `bypass_rs1` = `bypass_rs2` = 0 (constant).
  - `raw_hazard` = `match_rs1` | `match_rs2`. DX stalls until the write has committed.

## Structure
- Shared constants header holds:
  - `WB_SRC_SEL_WIDTH`, `WB_SRC_ALU`=0, `WB_SRC_MEM`=1, `WB_SRC_CSR`=2.
  - `MEM_TYPE_WIDTH` and the LB/LH/LW/LBU/LHU encodings (equal to RV32 funct3).
  - `XPR_LEN` and `REG_ADDR_WIDTH`.
- One combinational sub-module, `vscale_load_align`:
  - Inputs: `mem_type`, `addr[1:0]`, `dmem_rdata`.
  - Output: extended load data.

## Test plan
- ALU op, `rd`=5, `alu_out`=0x1234, no stall → next cycle `wr_reg_WB`=1, `reg_to_wr_WB`=5, `wb_data_WB`=0x1234.
- LB at addr 0x...3 with `dmem_rdata`=0x80FF_FF7F → 0xFFFF_FF80. LHU at addr 0x...2 with the same word → 0x0000_80FF.
- Load with `dmem_wait`=1 for 3 cycles → `stall_req_WB`=1 and `wr_reg_WB`=0 for those 3 cycles. Write occurs in cycle 4 with correct data; held fields are unchanged throughout.
- `stall_WB`=1 and `kill_DX`=1 together → WB holds its old instruction. `kill_DX` alone → bubble, `wr_reg_WB`=0 next cycle.
- `rd`=7 in WB, `rs1_addr_DX`=7:
  - Bypass enabled → `bypass_rs1`=1, `raw_hazard`=0. If the WB instruction is a waiting load → `bypass_rs1`=0, `raw_hazard`=1.
  - Bypass disabled → `raw_hazard`=1.
  - `rd`=0 with `rs1_addr_DX`=0 → no bypass, no hazard.
- Assert `reset` asynchronously mid-load → all outputs 0 immediately. No write occurs after reset is released.

Source files
------------

// File: rtl/vscale_wb_stage_pkg.sv
// vscale_wb_stage_pkg
// Shared constants and types for the writeback stage and its load aligner.
// Holds the datapath widths, the writeback source encodings, the load
// funct3 encodings (identical to RV32 funct3) and the WB register record.
// The optional bypass network in vscale_wb_stage is selected by the
// VSCALE_WB_BYPASS_EN macro; this package is the same in both builds.
package vscale_wb_stage_pkg;

   localparam int XPR_LEN          = 32;
   localparam int REG_ADDR_WIDTH   = 5;
   localparam int WB_SRC_SEL_WIDTH = 2;
   localparam int MEM_TYPE_WIDTH   = 3;

   // Writeback source select; encoding 3 is reserved and writes back zero.
   typedef enum logic [WB_SRC_SEL_WIDTH-1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_MEM = 2'd1,
      WB_SRC_CSR = 2'd2
   } wb_src_sel_t;

   // Load width/sign encodings, equal to the RV32 load funct3 field.
   typedef enum logic [MEM_TYPE_WIDTH-1:0] {
      MEM_TYPE_LB  = 3'd0,
      MEM_TYPE_LH  = 3'd1,
      MEM_TYPE_LW  = 3'd2,
      MEM_TYPE_LBU = 3'd4,
      MEM_TYPE_LHU = 3'd5
   } mem_type_t;

   // Everything the WB stage remembers about the instruction it holds.
   // Select fields are kept as plain vectors so reserved codes survive.
   typedef struct packed {
      logic                        valid;
      logic                        wr_reg;
      logic [REG_ADDR_WIDTH-1:0]   reg_to_wr;
      logic [WB_SRC_SEL_WIDTH-1:0] wb_src_sel;
      logic [MEM_TYPE_WIDTH-1:0]   mem_type;
      logic [XPR_LEN-1:0]          alu_out;
   } wb_regs_t;

endpackage

// File: rtl/vscale_load_align.sv
// vscale_load_align
// Purely combinational load-data extractor. Picks the addressed byte or
// halfword out of the returned memory word and sign- or zero-extends it.
// Ports:
//   mem_type   - load funct3 (LB, LH, LW, LBU, LHU)
//   addr       - low two bits of the load byte address
//   dmem_rdata - raw word returned by data memory
//   load_data  - aligned, extended result
// Unknown mem_type codes produce zero.
module vscale_load_align
   import vscale_wb_stage_pkg::*;
(
   input  logic [MEM_TYPE_WIDTH-1:0] mem_type,
   input  logic [1:0]                addr,
   input  logic [XPR_LEN-1:0]        dmem_rdata,
   output logic [XPR_LEN-1:0]        load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection: addr[0] is ignored for halfwords and both bits for
   // words, since misaligned accesses are trapped before reaching memory.
   always_comb begin
      byte_sel = dmem_rdata[7:0];
      case (addr)
         2'd0: byte_sel = dmem_rdata[7:0];
         2'd1: byte_sel = dmem_rdata[15:8];
         2'd2: byte_sel = dmem_rdata[23:16];
         2'd3: byte_sel = dmem_rdata[31:24];
         default: byte_sel = dmem_rdata[7:0];
      endcase
      half_sel = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   end

   // Extension according to the load type.
   always_comb begin
      load_data = '0;
      case (mem_type)
         MEM_TYPE_LB:  load_data = {{(XPR_LEN-8){byte_sel[7]}}, byte_sel};
         MEM_TYPE_LH:  load_data = {{(XPR_LEN-16){half_sel[15]}}, half_sel};
         MEM_TYPE_LW:  load_data = dmem_rdata;
         MEM_TYPE_LBU: load_data = {{(XPR_LEN-8){1'b0}}, byte_sel};
         MEM_TYPE_LHU: load_data = {{(XPR_LEN-16){1'b0}}, half_sel};
         default:      load_data = '0;
      endcase
   end

endmodule

// File: rtl/vscale_wb_stage.sv
// vscale_wb_stage
// Writeback pipeline stage between DX and the register file. Captures the
// DX results on every un-stalled edge, aligns returning load data, selects
// the writeback value and drives the register-file write port. Also tells
// DX whether its operands can be bypassed from WB or must wait (RAW).
// Configuration macro: VSCALE_WB_BYPASS_EN
//   defined   - operands matching WB are forwarded from wb_data_WB; only a
//               load still waiting on memory raises raw_hazard.
//   undefined - no forwarding; any match raises raw_hazard until the
//               write has committed.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   dx_*                      - instruction fields presented by DX
//   csr_rdata_WB              - CSR read data for the WB instruction
//   dmem_rdata, dmem_wait     - data-memory response
//   stall_WB, kill_DX         - pipeline control (stall wins over kill)
//   rs1_addr_DX, rs2_addr_DX  - DX source register indices
//   wr_reg_WB, reg_to_wr_WB   - register-file write enable / index
//   wb_data_WB                - write data, also the bypass value
//   stall_req_WB              - WB load still waiting on memory
//   bypass_rs1, bypass_rs2    - DX should take operand from wb_data_WB
//   raw_hazard                - DX must stall on a dependency with WB
module vscale_wb_stage
   import vscale_wb_stage_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dx_valid,
   input  logic                        dx_wr_reg,
   input  logic [REG_ADDR_WIDTH-1:0]   dx_reg_to_wr,
   input  logic [WB_SRC_SEL_WIDTH-1:0] dx_wb_src_sel,
   input  logic [MEM_TYPE_WIDTH-1:0]   dx_mem_type,
   input  logic [XPR_LEN-1:0]          dx_alu_out,
   input  logic [XPR_LEN-1:0]          csr_rdata_WB,
   input  logic [XPR_LEN-1:0]          dmem_rdata,
   input  logic                        dmem_wait,
   input  logic                        stall_WB,
   input  logic                        kill_DX,
   input  logic [REG_ADDR_WIDTH-1:0]   rs1_addr_DX,
   input  logic [REG_ADDR_WIDTH-1:0]   rs2_addr_DX,
   output logic                        wr_reg_WB,
   output logic [REG_ADDR_WIDTH-1:0]   reg_to_wr_WB,
   output logic [XPR_LEN-1:0]          wb_data_WB,
   output logic                        stall_req_WB,
   output logic                        bypass_rs1,
   output logic                        bypass_rs2,
   output logic                        raw_hazard
);

   wb_regs_t           wb;
   logic [XPR_LEN-1:0] load_data;
   logic               load_wait;
   logic               writes_rd;
   logic               match_rs1;
   logic               match_rs2;

   // WB register. A bubble only needs valid and wr_reg cleared; the other
   // fields are don't-care and are left alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb <= '0;
      end else if (!stall_WB) begin
         if (kill_DX || !dx_valid) begin
            wb.valid  <= 1'b0;
            wb.wr_reg <= 1'b0;
         end else begin
            wb.valid      <= 1'b1;
            wb.wr_reg     <= dx_wr_reg;
            wb.reg_to_wr  <= dx_reg_to_wr;
            wb.wb_src_sel <= dx_wb_src_sel;
            wb.mem_type   <= dx_mem_type;
            wb.alu_out    <= dx_alu_out;
         end
      end
   end

   vscale_load_align u_load_align (
      .mem_type   (wb.mem_type),
      .addr       (wb.alu_out[1:0]),
      .dmem_rdata (dmem_rdata),
      .load_data  (load_data)
   );

   // Writeback value selection; the reserved source code yields zero.
   always_comb begin
      wb_data_WB = '0;
      case (wb.wb_src_sel)
         WB_SRC_ALU: wb_data_WB = wb.alu_out;
         WB_SRC_MEM: wb_data_WB = load_data;
         WB_SRC_CSR: wb_data_WB = csr_rdata_WB;
         default:    wb_data_WB = '0;
      endcase
   end

   // Write-port control and dependency detection. x0 is never written and
   // never treated as a producer.
   always_comb begin
      load_wait    = wb.valid && (wb.wb_src_sel == WB_SRC_MEM) && dmem_wait;
      writes_rd    = wb.valid && wb.wr_reg && (wb.reg_to_wr != '0);
      match_rs1    = writes_rd && (wb.reg_to_wr == rs1_addr_DX);
      match_rs2    = writes_rd && (wb.reg_to_wr == rs2_addr_DX);
      stall_req_WB = load_wait;
      wr_reg_WB    = writes_rd && !load_wait;
      reg_to_wr_WB = wb.reg_to_wr;
   end

   // Forwarding decision. Without forwarding, DX has to wait for the
   // register file to commit the write before it can read the operand.
`ifdef VSCALE_WB_BYPASS_EN
   always_comb begin
      bypass_rs1 = match_rs1 && !load_wait;
      bypass_rs2 = match_rs2 && !load_wait;
      raw_hazard = (match_rs1 || match_rs2) && load_wait;
   end
`else
   always_comb begin
      bypass_rs1 = 1'b0;
      bypass_rs2 = 1'b0;
      raw_hazard = match_rs1 || match_rs2;
   end
`endif

endmodule

// File: tb/tb_vscale_wb_stage.sv
// tb_vscale_wb_stage
// Scoreboard bench for vscale_wb_stage. The stimulus side keeps an abstract
// model of the instruction held in WB, pushes every register write it
// expects into a queue, and checks the per-cycle status outputs. A monitor
// on the falling edge pops the queue whenever the DUT writes (and flags
// writes that are missing or unexpected).
module tb_vscale_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        dx_valid, dx_wr_reg;
   logic [4:0]  dx_reg_to_wr;
   logic [1:0]  dx_wb_src_sel;
   logic [2:0]  dx_mem_type;
   logic [31:0] dx_alu_out, csr_rdata_WB, dmem_rdata;
   logic        dmem_wait, stall_WB, kill_DX;
   logic [4:0]  rs1_addr_DX, rs2_addr_DX;
   logic        wr_reg_WB;
   logic [4:0]  reg_to_wr_WB;
   logic [31:0] wb_data_WB;
   logic        stall_req_WB, bypass_rs1, bypass_rs2, raw_hazard;

   typedef struct {
      logic        valid;
      logic        wr;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic [2:0]  mt;
      logic [31:0] alu;
   } inst_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t   exp_q[$];
   inst_t wb_m;
   int    compared   = 0;
   int    mismatched = 0;

   always #5 clk = ~clk;

   vscale_wb_stage dut (
      .clk           (clk),
      .reset         (reset),
      .dx_valid      (dx_valid),
      .dx_wr_reg     (dx_wr_reg),
      .dx_reg_to_wr  (dx_reg_to_wr),
      .dx_wb_src_sel (dx_wb_src_sel),
      .dx_mem_type   (dx_mem_type),
      .dx_alu_out    (dx_alu_out),
      .csr_rdata_WB  (csr_rdata_WB),
      .dmem_rdata    (dmem_rdata),
      .dmem_wait     (dmem_wait),
      .stall_WB      (stall_WB),
      .kill_DX       (kill_DX),
      .rs1_addr_DX   (rs1_addr_DX),
      .rs2_addr_DX   (rs2_addr_DX),
      .wr_reg_WB     (wr_reg_WB),
      .reg_to_wr_WB  (reg_to_wr_WB),
      .wb_data_WB    (wb_data_WB),
      .stall_req_WB  (stall_req_WB),
      .bypass_rs1    (bypass_rs1),
      .bypass_rs2    (bypass_rs2),
      .raw_hazard    (raw_hazard)
   );

   // Reference load result: shift the addressed lane down, then extend.
   function automatic logic [31:0] load_model(input logic [2:0] mt,
                                              input logic [31:0] addr,
                                              input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> (8 * addr[1:0]));
      h = 16'(word >> (16 * addr[1]));
      case (mt)
         3'd0:    return 32'($signed(b));
         3'd1:    return 32'($signed(h));
         3'd2:    return word;
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] exp_data(input inst_t i, input logic [31:0] rdata,
                                            input logic [31:0] csr);
      case (i.src)
         2'd0:    return i.alu;
         2'd1:    return load_model(i.mt, i.alu, rdata);
         2'd2:    return csr;
         default: return 32'd0;
      endcase
   endfunction

   function automatic inst_t mk(input logic [4:0] rd, input logic [1:0] src,
                                input logic [2:0] mt, input logic [31:0] alu);
      inst_t i;
      i.valid = 1'b1; i.wr = 1'b1; i.rd = rd; i.src = src; i.mt = mt; i.alu = alu;
      return i;
   endfunction

   function automatic inst_t rand_inst();
      logic [2:0] mt_tab [5];
      inst_t i;
      mt_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      i.valid = ($urandom % 4) != 0;
      i.wr    = ($urandom % 4) != 0;
      i.rd    = 5'($urandom);
      i.src   = 2'($urandom);
      i.mt    = mt_tab[$urandom % 5];
      i.alu   = $urandom;
      return i;
   endfunction

   function automatic logic [4:0] pick_rs();
      return (($urandom % 2) != 0) ? wb_m.rd : 5'($urandom);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus, entered and left 1 time unit after a
   // rising edge. Expected write and status come from the WB model.
   task automatic applyStimulus(input inst_t dx, input logic stall, input logic kill,
                                input logic dwait, input logic [31:0] rdata,
                                input logic [31:0] csr, input logic [4:0] rs1,
                                input logic [4:0] rs2);
      logic lw, wr_exp, m1, m2, eb1, eb2, ehz;
      wr_t  e;
      dx_valid      = dx.valid;
      dx_wr_reg     = dx.wr;
      dx_reg_to_wr  = dx.rd;
      dx_wb_src_sel = dx.src;
      dx_mem_type   = dx.mt;
      dx_alu_out    = dx.alu;
      stall_WB      = stall;
      kill_DX       = kill;
      dmem_wait     = dwait;
      dmem_rdata    = rdata;
      csr_rdata_WB  = csr;
      rs1_addr_DX   = rs1;
      rs2_addr_DX   = rs2;
      lw     = wb_m.valid && (wb_m.src == 2'd1) && dwait;
      wr_exp = wb_m.valid && wb_m.wr && (wb_m.rd != 5'd0) && !lw;
      if (wr_exp) begin
         e.rd   = wb_m.rd;
         e.data = exp_data(wb_m, rdata, csr);
         exp_q.push_back(e);
      end
      m1 = wb_m.valid && wb_m.wr && (wb_m.rd != 5'd0) && (wb_m.rd == rs1);
      m2 = wb_m.valid && wb_m.wr && (wb_m.rd != 5'd0) && (wb_m.rd == rs2);
`ifdef VSCALE_WB_BYPASS_EN
      eb1 = m1 && !lw;
      eb2 = m2 && !lw;
      ehz = (m1 || m2) && lw;
`else
      eb1 = 1'b0;
      eb2 = 1'b0;
      ehz = m1 || m2;
`endif
      #1;
      checkOutput("stall_req_WB", 64'(stall_req_WB), 64'(lw));
      checkOutput("bypass_rs1", 64'(bypass_rs1), 64'(eb1));
      checkOutput("bypass_rs2", 64'(bypass_rs2), 64'(eb2));
      checkOutput("raw_hazard", 64'(raw_hazard), 64'(ehz));
      @(posedge clk);
      if (!stall) begin
         if (kill || !dx.valid) begin
            wb_m.valid = 1'b0;
            wb_m.wr    = 1'b0;
         end else begin
            wb_m = dx;
         end
      end
      #1;
   endtask

   // Monitor: every DUT write must match the head of the queue, and every
   // expected write must show up in the same cycle it was scheduled.
   always @(negedge clk) begin
      wr_t e;
      if (wr_reg_WB === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_write: got rd %0d data %0h, expected no write",
                     reg_to_wr_WB, wb_data_WB);
         end else begin
            e = exp_q.pop_front();
            checkOutput("write_rd", 64'(reg_to_wr_WB), 64'(e.rd));
            checkOutput("write_data", 64'(wb_data_WB), 64'(e.data));
         end
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL missing_write: got no write, expected rd %0d data %0h",
                  e.rd, e.data);
      end
   end

   initial begin
      inst_t idle;
      inst_t ld;
      logic  is_ld;
      int    n;
      idle = '{default: 0};
      wb_m = '{default: 0};
      reset = 1'b1;
      dx_valid = 0; dx_wr_reg = 0; dx_reg_to_wr = 0; dx_wb_src_sel = 0;
      dx_mem_type = 0; dx_alu_out = 0; csr_rdata_WB = 32'hDEAD_BEEF;
      dmem_rdata = 32'hFFFF_FFFF; dmem_wait = 0; stall_WB = 0; kill_DX = 0;
      rs1_addr_DX = 0; rs2_addr_DX = 0;
      #12;
      checkOutput("reset_outputs",
                  {wr_reg_WB, reg_to_wr_WB, wb_data_WB, stall_req_WB,
                   bypass_rs1, bypass_rs2, raw_hazard}, 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // ALU write, then LB addr 3 and LHU addr 2 on word 0x80FFFF7F.
      applyStimulus(mk(5'd5, 2'd0, 3'd0, 32'h1234), 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(mk(5'd3, 2'd1, 3'd0, 32'h1003), 0, 0, 0, 32'h80FF_FF7F, 0, 0, 0);
      applyStimulus(mk(5'd4, 2'd1, 3'd5, 32'h2002), 0, 0, 0, 32'h80FF_FF7F, 0, 0, 0);
      applyStimulus(mk(5'd9, 2'd1, 3'd2, 32'h3000), 0, 0, 0, 32'h80FF_FF7F, 0, 0, 0);
      // Load waiting three cycles with stall and kill both asserted.
      for (int i = 0; i < 3; i++)
         applyStimulus(mk(5'd1, 2'd0, 3'd0, 32'h5555), 1, 1, 1, $urandom, 0, 0, 0);
      applyStimulus(mk(5'd11, 2'd0, 3'd0, 32'hABCD), 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0);
      // Stall with kill holds an ALU result; kill alone makes a bubble.
      applyStimulus(mk(5'd6, 2'd0, 3'd0, 32'h77), 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(mk(5'd6, 2'd0, 3'd0, 32'h77), 0, 1, 0, 0, 0, 0, 0);
      // Dependency on rd=7: ALU producer, then waiting load producer.
      applyStimulus(mk(5'd7, 2'd0, 3'd0, 32'h700), 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(mk(5'd7, 2'd1, 3'd2, 32'h800), 0, 0, 0, 0, 0, 5'd7, 0);
      applyStimulus(idle, 1, 0, 1, 0, 0, 5'd7, 5'd7);
      applyStimulus(mk(5'd0, 2'd0, 3'd0, 32'h900), 0, 0, 0, 32'h1357_9BDF, 0, 5'd7, 0);
      applyStimulus(idle, 0, 0, 0, 0, 0, 5'd0, 5'd0);

      // Randomized traffic; loads wait a random number of cycles.
      repeat (150) begin
         is_ld = wb_m.valid && (wb_m.src == 2'd1);
         n = is_ld ? $urandom_range(0, 3) : (($urandom_range(0, 3) == 0) ? 1 : 0);
         for (int i = 0; i < n; i++)
            applyStimulus(rand_inst(), 1, 1'($urandom), is_ld ? 1'b1 : 1'($urandom),
                          $urandom, $urandom, pick_rs(), pick_rs());
         applyStimulus(rand_inst(), 0, ($urandom_range(0, 5) == 0), 0,
                       $urandom, $urandom, pick_rs(), pick_rs());
      end

      // Asynchronous reset in the middle of a load wait.
      ld = mk(5'd12, 2'd1, 3'd2, 32'h40);
      applyStimulus(ld, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(ld, 0, 0, 0, 0, 0, 0, 0);
      dx_valid = 0; stall_WB = 1; dmem_wait = 1; rs1_addr_DX = 5'd12;
      #3 reset = 1'b1;
      #1;
      checkOutput("reset_midload",
                  {wr_reg_WB, reg_to_wr_WB, wb_data_WB, stall_req_WB,
                   bypass_rs1, bypass_rs2, raw_hazard}, 64'd0);
      @(posedge clk);
      #1;
      stall_WB = 0; dmem_wait = 0;
      reset = 1'b0;
      wb_m = '{default: 0};
      repeat (3) applyStimulus(idle, 0, 0, 0, $urandom, $urandom, 5'd12, 5'd12);

      @(negedge clk);
      #1;
      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
